hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It is the driving end of the pipeline-register control interface: it produces the stall enables, the flush/clear signals consumed by the ID/EX and MEM/WB registers, and the forwarding selects. It combines combinational forwarding and load-use/branch detection with a sequential memory-wait state machine, a timeout watchdog and a saturating stall-cycle counter.

## Interface
- TIMEOUT, 16: maximum cycles a MEM access may wait for `MemReadyM` before a fatal timeout; legal range 2..255.
- CNT_W, 32: width of the stall-cycle counter.

- clk  in  1  pipeline clock, all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- RsD, RtD  in  5  source registers in ID
- BranchD  in  1  branch in ID; operands are compared in ID
- RsE, RtE, WriteRegE  in  5  EX source and destination registers
- RegWriteE, MemtoRegE  in  1  EX writes a register / EX is a load
- WriteRegM  in  5  MEM destination register
- RegWriteM, MemtoRegM  in  1  MEM writes a register / MEM is a load
- MemReqM  in  1  MEM stage is accessing data memory this cycle
- MemReadyM  in  1  data memory completes the access this cycle
- WriteRegW  in  5  WB destination register
- RegWriteW  in  1  WB writes a register
- StallF, StallD, StallE, StallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers
- FlushE  out  1  drives the `clr` input of the ID/EX register
- FlushW  out  1  clears the MEM/WB register
- ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result
- ForwardAD, ForwardBD  out  1  ID branch-comparator operand taken from the MEM ALU result
- MemTimeout  out  1  sticky fatal-error flag
- StallCount  out  CNT_W  number of cycles with StallF high, saturating

## Operation
- Register 0 never matches: no forward and no stall is caused by register 0.
- ForwardAE is 10 if RsE==WriteRegM and RegWriteM. Otherwise it is 01 if RsE==WriteRegW and RegWriteW. Otherwise it is 00. MEM has priority over WB. ForwardBE follows the same rules using RtE.
- ForwardAD = (RsD==WriteRegM) & RegWriteM. ForwardBD is the same using RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- memstall = MemReqM & ~MemReadyM, or state ≠ RUN.
- If memstall is true: StallF=StallD=StallE=StallM=1, FlushE=0, FlushW=1. memstall overrides lwstall and brstall.
- Otherwise, if lwstall or brstall is true: StallF=StallD=1, FlushE=1, StallE=StallM=FlushW=0.
- Otherwise all stall and flush outputs are 0.

FSM, with states RUN, WAIT and ERROR:
- RUN:
  - If MemReqM & ~MemReadyM, go to WAIT and set wait_cnt=1.
- WAIT:
  - If MemReadyM, go to RUN. The stall is released in that same cycle, so the access completes.
  - Else if wait_cnt==TIMEOUT-1, go to ERROR.
  - Else increment wait_cnt.
- ERROR:
  - MemTimeout=1 and all four stalls are held.
  - The block leaves ERROR only through reset.
- StallCount increments on each rising edge where StallF=1 and saturates at all-ones.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, StallCount=0, MemTimeout=0.
  - Outputs then follow the combinational rules. With all inputs idle, every stall and flush output and every forward select is 0.
- Forwarding, lwstall and brstall are purely combinational, with zero latency.
- A memory stall is asserted combinationally in the first cycle MemReqM & ~MemReadyM is seen. It remains asserted through every cycle of WAIT until MemReadyM is seen.
- TIMEOUT counts total not-ready cycles including the first. With TIMEOUT=16, the 16th consecutive not-ready cycle is the last one spent in WAIT. MemTimeout rises on the following clock edge.
- If MemReadyM and the TIMEOUT limit occur in the same cycle, MemReadyM wins and the FSM returns to RUN.
- rst_n deasserted mid-WAIT or in ERROR takes effect immediately. Outputs revert to the combinational rules with state=RUN.
- StallCount reflects a stall on the edge following the stalled cycle.

## Test plan
- Forward priority: WriteRegM=WriteRegW=RsE=5 with RegWriteM=RegWriteW=1 gives ForwardAE=10. Drop RegWriteM and ForwardAE=01. Set RsE=0 and ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 gives StallF=StallD=FlushE=1 for exactly one cycle. StallCount then reads 1.
- Branch: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 gives StallF=StallD=FlushE=1. With MemtoRegM=0, WriteRegM=3, RegWriteM=1, no stall occurs and ForwardAD=1.
- Memory wait: MemReqM=1 with MemReadyM low for 4 cycles, then high. All stalls and FlushW stay high for 4 cycles and fall in the ready cycle. Throughout, lwstall stimulus is present and FlushE stays 0.
- Timeout: with TIMEOUT=4 and MemReadyM held low, MemTimeout=1 after the 4th not-ready cycle. Stalls stay high even after MemReadyM rises, and clear only on rst_n=0.
- Reset mid-WAIT: rst_n pulsed low in the 2nd wait cycle. StallCount=0, MemTimeout=0, and the FSM is in RUN immediately without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: forwarding selects, load-use/branch stalls, memory-wait FSM with timeout watchdog.
// Latency: forwarding and stall/flush outputs are combinational (0 cycles); MemTimeout and StallCount update on the clock edge.
// Backpressure: a not-ready data memory stalls the whole pipeline until ready, or permanently after TIMEOUT not-ready cycles.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   RsD, RtD, BranchD                  ID source registers and branch-in-ID flag
//   RsE, RtE, WriteRegE                EX source/destination registers
//   RegWriteE, MemtoRegE               EX writes a register / EX is a load
//   WriteRegM, RegWriteM, MemtoRegM    MEM destination, register write, load flag
//   MemReqM, MemReadyM                 MEM data access request / completion
//   WriteRegW, RegWriteW               WB destination and register write
//   StallF/D/E/M                       hold PC, IF/ID, ID/EX, EX/MEM registers
//   FlushE, FlushW                     clear ID/EX and MEM/WB registers
//   ForwardAE/BE                       EX operand select (00 RF, 01 WB, 10 MEM)
//   ForwardAD/BD                       ID comparator operand from MEM ALU result
//   MemTimeout                         sticky fatal memory timeout
//   StallCount                         saturating count of StallF cycles
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic             BranchD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    // wait_cnt holds the number of not-ready cycles already seen; the first one
    // is spent in RUN, so the limit check in WAIT is against TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       mem_stall;
    logic       lw_stall;
    logic       br_stall;

    // Register 0 is hard-wired zero and must never create a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // EX operand forwarding: the younger result in MEM beats WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (RegWriteM && reg_hit(src, WriteRegM)) begin
            return 2'b10;
        end else if (RegWriteW && reg_hit(src, WriteRegW)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(RsE);
        ForwardBE = fwd_sel(RtE);
        ForwardAD = RegWriteM && reg_hit(RsD, WriteRegM);
        ForwardBD = RegWriteM && reg_hit(RtD, WriteRegM);
    end

    // A load in EX cannot forward its data in time to an ID consumer.
    assign lw_stall = MemtoRegE && (reg_hit(RtE, RsD) || reg_hit(RtE, RtD));

    // Branches resolve in ID, so an EX ALU result or a MEM load feeding the
    // comparator is not yet available. A MEM ALU result is forwarded instead.
    assign br_stall = BranchD &&
                      ((RegWriteE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD))) ||
                       (MemtoRegM && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Memory-wait FSM. mem_stall drops in the ready cycle of WAIT so the
    // access retires on that edge; ERROR holds the pipeline until reset.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        case (state)
            S_RUN: begin
                if (MemReqM && !MemReadyM) begin
                    mem_stall    = 1'b1;
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            S_WAIT: begin
                if (MemReadyM) begin
                    state_nxt    = S_RUN;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = S_ERROR;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
            end
            S_ERROR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_nxt    = S_RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // A memory stall freezes every stage and bubbles WB; it takes precedence
    // over the ID hazards, which only bubble EX.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (lw_stall || br_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign MemTimeout = (state == S_ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
        end else if (StallF && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule
